// File: rtl/cont_multimodo_param_if.sv
// rtl/cont_multimodo_param_if.sv - control and output bundle for the multi-mode counter
interface cont_multimodo_param_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (output en, mode, dir, load, d, input q, tc);
  modport slave  (input en, mode, dir, load, d, output q, tc);
endinterface

// File: rtl/cont_multimodo_param.sv
// rtl/cont_multimodo_param.sv - binary/Gray modulo-N, Johnson and ring counter on one state register
module cont_multimodo_param #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input logic                   ck,
  input logic                   clr,
  cont_multimodo_param_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_BIN  = 2'b00,
    MODE_GRAY = 2'b01,
    MODE_JOHN = 2'b10,
    MODE_RING = 2'b11
  } mode_e;

  // MODULO may equal 2^WIDTH, so range compares are done one bit wider.
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB    = ONE << (WIDTH - 1);

  logic [WIDTH-1:0] r_q, r_d;
  logic             in_range;
  mode_e            mode_s;

  assign mode_s   = mode_e'(bus.mode);
  assign in_range = ({1'b0, r_q} < MOD_W);

  always_comb begin
    r_d = r_q;
    if (bus.load) begin
      if (mode_s == MODE_BIN || mode_s == MODE_GRAY)
        r_d = ({1'b0, bus.d} < MOD_W) ? bus.d : '0;
      else
        r_d = bus.d;
    end else if (bus.en) begin
      unique case (mode_s)
        MODE_BIN, MODE_GRAY: begin
          // Out-of-range values left over from another mode recover in one step.
          if (bus.dir)
            r_d = (r_q == MOD_M1 || !in_range) ? '0 : r_q + ONE;
          else
            r_d = (r_q == '0 || !in_range) ? MOD_M1 : r_q - ONE;
        end
        MODE_JOHN: begin
          if (bus.dir) r_d = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
          else         r_d = {~r_q[0], r_q[WIDTH-1:1]};
        end
        MODE_RING: begin
          if (r_q == '0)   r_d = bus.dir ? ONE : MSB;
          else if (bus.dir) r_d = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          else              r_d = {r_q[0], r_q[WIDTH-1:1]};
        end
        default: r_d = r_q;
      endcase
    end
  end

  always_ff @(posedge ck or negedge clr) begin
    if (!clr) r_q <= '0;
    else      r_q <= r_d;
  end

  always_comb begin
    bus.q  = r_q;
    bus.tc = 1'b0;
    unique case (mode_s)
      MODE_BIN:  bus.tc = bus.dir ? (r_q == MOD_M1) : (r_q == '0);
      MODE_GRAY: begin
        bus.q  = r_q ^ (r_q >> 1);
        bus.tc = bus.dir ? (r_q == MOD_M1) : (r_q == '0);
      end
      MODE_JOHN: bus.tc = bus.dir ? (r_q == MSB) : (r_q == ONE);
      MODE_RING: bus.tc = bus.dir ? r_q[WIDTH-1] : r_q[0];
      default:   bus.tc = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_cont_multimodo_param.sv
// tb/tb_cont_multimodo_param.sv - directed plan plus randomized run against a behavioural counter model
module tb_cont_multimodo_param;
  localparam int W = 4;
  localparam int M = 10;
  localparam int unsigned MASK = (1 << W) - 1;

  logic ck = 1'b0;
  logic clr;
  int   n_chk = 0;
  int   n_pass = 0;
  int unsigned m_r = 0;

  always #5 ck = ~ck;

  cont_multimodo_param_if #(.WIDTH(W)) bus ();
  cont_multimodo_param #(.WIDTH(W), .MODULO(M)) dut (.ck(ck), .clr(clr), .bus(bus));

  function automatic int unsigned m_next(int unsigned r, logic ld, logic e, logic [1:0] md,
                                         logic dr, int unsigned dv);
    if (ld) return (md < 2) ? ((dv < M) ? dv : 0) : dv;
    if (!e) return r;
    case (md)
      2'd0, 2'd1: begin
        if (dr) return (r >= M - 1) ? 0 : r + 1;
        return (r == 0 || r >= M) ? M - 1 : r - 1;
      end
      2'd2: begin
        if (dr) return ((r << 1) | (((r >> (W - 1)) & 1) ^ 1)) & MASK;
        return (r >> 1) | (((r & 1) ^ 1) << (W - 1));
      end
      default: begin
        if (r == 0) return dr ? 1 : (1 << (W - 1));
        if (dr) return ((r << 1) | (r >> (W - 1))) & MASK;
        return (r >> 1) | ((r & 1) << (W - 1));
      end
    endcase
  endfunction

  function automatic int unsigned m_q(int unsigned r, logic [1:0] md);
    return (md == 2'd1) ? (r ^ (r >> 1)) : r;
  endfunction

  function automatic int unsigned m_tc(int unsigned r, logic [1:0] md, logic dr);
    case (md)
      2'd0, 2'd1: return dr ? int'(r == M - 1) : int'(r == 0);
      2'd2:       return dr ? int'(r == (1 << (W - 1))) : int'(r == 1);
      default:    return dr ? ((r >> (W - 1)) & 1) : (r & 1);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_ctl(input logic ld, input logic e, input logic [1:0] md, input logic dr,
                         input int unsigned dv);
    bus.load = ld;
    bus.en   = e;
    bus.mode = md;
    bus.dir  = dr;
    bus.d    = W'(dv);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},  32'(bus.q),  m_q(m_r, bus.mode));
    chk({tag, ".tc"}, 32'(bus.tc), m_tc(m_r, bus.mode, bus.dir));
  endtask

  task automatic tick(input string tag);
    int unsigned nx;
    nx = m_next(m_r, bus.load, bus.en, bus.mode, bus.dir, int'(bus.d));
    @(posedge ck);
    #1;
    m_r = clr ? nx : 0;
    check_model(tag);
  endtask

  task automatic tick_exp(input string tag, input int unsigned exp_q);
    tick(tag);
    chk({tag, ".plan"}, 32'(bus.q), exp_q);
  endtask

  // Pulse reset between edges and confirm it acts without waiting for ck.
  task automatic do_reset(input string tag);
    clr = 1'b0;
    #1;
    m_r = 0;
    chk({tag, ".rst"}, 32'(bus.q), 0);
    clr = 1'b1;
  endtask

  int unsigned gray_seq[10] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b0000};
  int unsigned john_up[8]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
  int unsigned john_dn[8]   = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};
  int unsigned ring_seq[5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    clr = 1'b0;
    set_ctl(1'b0, 1'b0, 2'd0, 1'b1, 0);
    #2;
    chk("reset.q", 32'(bus.q), 0);
    chk("reset.tc", 32'(bus.tc), 0);
    clr = 1'b1;

    // 1: binary up wraps at 9 -> 0
    set_ctl(1'b0, 1'b1, 2'd0, 1'b1, 0);
    for (int i = 1; i <= 11; i++) tick_exp("bin_up", i % M);

    // 2: Gray up, then one step down from index 0
    do_reset("gray");
    set_ctl(1'b0, 1'b1, 2'd1, 1'b1, 0);
    for (int i = 0; i < 10; i++) tick_exp("gray_up", gray_seq[i]);
    bus.dir = 1'b0;
    #1;
    chk("gray_dn.tc0", 32'(bus.tc), 1);
    tick_exp("gray_dn", 4'b1101);

    // 3: Johnson both directions
    do_reset("john");
    set_ctl(1'b0, 1'b1, 2'd2, 1'b1, 0);
    for (int i = 0; i < 8; i++) tick_exp("john_up", john_up[i]);
    set_ctl(1'b0, 1'b1, 2'd2, 1'b0, 0);
    for (int i = 0; i < 8; i++) tick_exp("john_dn", john_dn[i]);

    // 4: ring self-start, rotation, multi-hot load
    do_reset("ring");
    set_ctl(1'b0, 1'b1, 2'd3, 1'b1, 0);
    for (int i = 0; i < 5; i++) tick_exp("ring_up", ring_seq[i]);
    set_ctl(1'b1, 1'b1, 2'd3, 1'b1, 4'b0101);
    tick_exp("ring_ld", 4'b0101);
    bus.load = 1'b0;
    tick_exp("ring_rot", 4'b1010);
    tick_exp("ring_rot", 4'b0101);

    // 5: load priority, out-of-range load, reinterpretation after mode change
    set_ctl(1'b1, 1'b1, 2'd0, 1'b1, 12);
    tick_exp("ld_range", 0);
    set_ctl(1'b1, 1'b0, 2'd0, 1'b1, 7);
    tick_exp("ld_noen", 7);
    set_ctl(1'b1, 1'b0, 2'd2, 1'b1, 15);
    tick_exp("ld_john", 15);
    set_ctl(1'b0, 1'b1, 2'd0, 1'b1, 0);
    tick_exp("oor_up", 0);
    set_ctl(1'b1, 1'b0, 2'd2, 1'b1, 15);
    tick_exp("ld_john2", 15);
    set_ctl(1'b0, 1'b1, 2'd0, 1'b0, 0);
    tick_exp("oor_dn", 9);

    // 6: asynchronous reset mid-count
    do_reset("async");
    set_ctl(1'b0, 1'b1, 2'd0, 1'b1, 0);
    for (int i = 1; i <= 6; i++) tick_exp("async_cnt", i);
    #2;
    clr = 1'b0;
    #1;
    m_r = 0;
    chk("async.imm", 32'(bus.q), 0);
    for (int i = 0; i < 3; i++) tick_exp("async_hold", 0);
    clr = 1'b1;
    tick_exp("async_resume", 1);

    // Randomized run; occasional async reset pulses between edges.
    for (int i = 0; i < 400; i++) begin
      set_ctl(($urandom_range(7) == 0), ($urandom_range(3) != 0),
              ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : bus.mode,
              1'($urandom_range(1)), $urandom_range(MASK));
      if ($urandom_range(40) == 0) do_reset("rand");
      #1;
      check_model("rand_comb");
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
